// File: rtl/div_unit.sv
// Multi-cycle restoring divider: signed or unsigned quotient and remainder,
// one quotient bit per clock, under a start/ready handshake with flush support.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               divzero_o,
    output logic               busy_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [WIDTH-1:0]   rem_r, rem_n, quo_r, quo_n, dvs_r, dvs_n;
    logic               q_sign, q_sign_n, r_sign, r_sign_n;
    logic [2*WIDTH-1:0] result_n;
    logic               ready_n, divzero_n;

    logic [WIDTH:0]     shifted, trial;
    logic [WIDTH-1:0]   quo_step, rem_step, abs1, abs2;

    // Partial remainder stays below the divisor, so a (WIDTH+1)-bit trial
    // difference carries its true sign in the top bit.
    always_comb begin
        shifted  = {rem_r, quo_r[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_r};
        quo_step = {quo_r[WIDTH-2:0], ~trial[WIDTH]};
        rem_step = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        abs1     = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        abs2     = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        rem_n     = rem_r;
        quo_n     = quo_r;
        dvs_n     = dvs_r;
        q_sign_n  = q_sign;
        r_sign_n  = r_sign;
        result_n  = result_o;
        ready_n   = ready_o;
        divzero_n = divzero_o;
        if (annul_i) begin
            state_n   = IDLE;
            result_n  = '0;
            ready_n   = 1'b0;
            divzero_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (opdata2_i == '0) begin
                            state_n = DIVZERO;
                        end else begin
                            state_n  = ON;
                            quo_n    = abs1;
                            rem_n    = '0;
                            dvs_n    = abs2;
                            cnt_n    = '0;
                            q_sign_n = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                            r_sign_n = signed_div_i & opdata1_i[WIDTH-1];
                        end
                    end
                end
                DIVZERO: begin
                    state_n   = END;
                    result_n  = '0;
                    ready_n   = 1'b1;
                    divzero_n = 1'b1;
                end
                ON: begin
                    quo_n = quo_step;
                    rem_n = rem_step;
                    cnt_n = cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state_n   = END;
                        result_n  = {r_sign ? -rem_step : rem_step,
                                     q_sign ? -quo_step : quo_step};
                        ready_n   = 1'b1;
                        divzero_n = 1'b0;
                    end
                end
                END: begin
                    if (!start_i) begin
                        state_n   = IDLE;
                        result_n  = '0;
                        ready_n   = 1'b0;
                        divzero_n = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            dvs_r     <= '0;
            q_sign    <= 1'b0;
            r_sign    <= 1'b0;
            result_o  <= '0;
            ready_o   <= 1'b0;
            divzero_o <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rem_r     <= rem_n;
            quo_r     <= quo_n;
            dvs_r     <= dvs_n;
            q_sign    <= q_sign_n;
            r_sign    <= r_sign_n;
            result_o  <= result_n;
            ready_o   <= ready_n;
            divzero_o <= divzero_n;
        end
    end

    assign busy_o = (state == ON) || (state == DIVZERO);

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit at WIDTH=32 and WIDTH=8, checked against an
// arithmetic reference model plus hand-computed literals.
module tb_div_unit;

    logic        clk, rst;
    logic        start32, annul32, sgn32;
    logic [31:0] a32, b32;
    logic [63:0] res32;
    logic        rdy32, dz32, busy32;
    logic        start8, annul8, sgn8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;
    logic        rdy8, dz8, busy8;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_res32, exp_res8;
    logic        exp_dz32, exp_dz8;

    div_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start_i(start32), .annul_i(annul32),
        .signed_div_i(sgn32), .opdata1_i(a32), .opdata2_i(b32),
        .result_o(res32), .ready_o(rdy32), .divzero_o(dz32), .busy_o(busy32)
    );

    div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .annul_i(annul8),
        .signed_div_i(sgn8), .opdata1_i(a8), .opdata2_i(b8),
        .result_o(res8), .ready_o(rdy8), .divzero_o(dz8), .busy_o(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Truncating division on wide integers; result packed as {rem, quo} in w bits each.
    function automatic logic [63:0] model(input int w, input bit sgn,
                                          input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] mask, qb, rb;
        if (b == 0) return '0;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
        q    = sa / sb;
        r    = sa % sb;
        mask = (64'd1 << w) - 64'd1;
        qb   = q;
        rb   = r;
        return ((rb & mask) << w) | (qb & mask);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (rdy32) begin
                check("cmp32_result", res32, exp_res32);
                check("cmp32_divzero", {63'd0, dz32}, {63'd0, exp_dz32});
            end else begin
                check("cmp32_idle_out", {res32[62:0], dz32}, 64'd0);
            end
            if (rdy8) begin
                check("cmp8_result", {48'd0, res8}, exp_res8);
                check("cmp8_divzero", {63'd0, dz8}, {63'd0, exp_dz8});
            end else begin
                check("cmp8_idle_out", {47'd0, res8, dz8}, 64'd0);
            end
        end
    end

    // Called just after a rising edge; leaves start low for one edge afterwards.
    task automatic run32(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] lit, input string name);
        int n;
        exp_res32 = model(32, sgn, a, b);
        exp_dz32  = (b == 0);
        sgn32 = sgn; a32 = a; b32 = b; start32 = 1'b1;
        n = 0;
        while (!rdy32 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (n == 1 && b != 0) check({name, "_busy"}, {63'd0, busy32}, 64'd1);
            if (n == 5) begin a32 = ~a; b32 = b + 32'd1; end
        end
        check({name, "_latency"}, 64'(n), (b == 0) ? 64'd2 : 64'd33);
        check({name, "_lit"}, res32, lit);
        check({name, "_busy_end"}, {63'd0, busy32}, 64'd0);
        start32 = 1'b0;
        @(posedge clk); #1;
        check({name, "_drop"}, {res32[62:0], rdy32}, 64'd0);
    endtask

    task automatic run8(input bit sgn, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] lit, input string name);
        int n;
        exp_res8 = model(8, sgn, {24'd0, a}, {24'd0, b});
        exp_dz8  = (b == 0);
        sgn8 = sgn; a8 = a; b8 = b; start8 = 1'b1;
        n = 0;
        while (!rdy8 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_latency"}, 64'(n), (b == 0) ? 64'd2 : 64'd9);
        check({name, "_lit"}, {48'd0, res8}, {48'd0, lit});
        start8 = 1'b0;
        @(posedge clk); #1;
        check({name, "_drop"}, {47'd0, res8, rdy8}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        start32 = 0; annul32 = 0; sgn32 = 0; a32 = '0; b32 = '0;
        start8 = 0; annul8 = 0; sgn8 = 0; a8 = '0; b8 = '0;
        exp_res32 = '0; exp_res8 = '0; exp_dz32 = 0; exp_dz8 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset32_out", {res32, rdy32, dz32, busy32} >> 3, 64'd0);
        check("reset32_flags", {61'd0, rdy32, dz32, busy32}, 64'd0);
        check("reset8_out", {45'd0, res8, rdy8, dz8, busy8}, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        run32(0, 32'd100, 32'd7, 64'h00000002_0000000E, "u100_7");
        run32(1, -32'sd7, 32'd2, 64'hFFFFFFFF_FFFFFFFD, "s-7_2");
        run32(1, 32'd7, -32'sd2, 64'h00000001_FFFFFFFD, "s7_-2");
        run32(1, -32'sd100, -32'sd7, 64'hFFFFFFFE_0000000E, "s-100_-7");
        run32(0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, "umax_1");
        run32(1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "s_ovf");
        run32(0, 32'd5, 32'd9, 64'h00000005_00000000, "u5_9");
        run32(0, 32'd55, 32'd0, 64'd0, "divzero");

        // start and annul together in IDLE: nothing accepted
        a32 = 32'd40; b32 = 32'd5; start32 = 1'b1; annul32 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("annul_idle", {61'd0, busy32, rdy32, dz32}, 64'd0);
        start32 = 1'b0; annul32 = 1'b0;
        @(posedge clk); #1;

        // flush mid-operation, then restart immediately
        exp_res32 = model(32, 0, 32'd1000, 32'd3); exp_dz32 = 0;
        sgn32 = 0; a32 = 32'd1000; b32 = 32'd3; start32 = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        annul32 = 1'b1;
        @(posedge clk); #1;
        check("annul_mid", {res32[60:0], busy32, rdy32, dz32}, 64'd0);
        annul32 = 1'b0;
        run32(0, 32'd9, 32'd3, 64'h00000000_00000003, "u9_3");

        // asynchronous reset mid-operation
        exp_res32 = model(32, 0, 32'd500, 32'd7); exp_dz32 = 0;
        sgn32 = 0; a32 = 32'd500; b32 = 32'd7; start32 = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_busy", {63'd0, busy32}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", {res32[60:0], busy32, rdy32, dz32}, 64'd0);
        start32 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run32(0, 32'd20, 32'd6, 64'h00000002_00000003, "u20_6");

        run8(1, 8'h80, 8'hFF, 16'h0080, "w8_s_ovf");
        run8(0, 8'hFF, 8'h10, 16'h0F0F, "w8_uFF_10");
        run8(1, 8'hF9, 8'h02, 16'hFFFD, "w8_s-7_2");
        run8(0, 8'd12, 8'd0, 16'h0000, "w8_divzero");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
